// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream; signal suffixes are relative to the drain stage.
// master = drain stage (issues reads, sources the stream), slave = FIFO/consumer side.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 18
);
  logic                  fifo_ne_i;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_rd_o;
  logic                  fifo_oe_o;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;

  modport master (
    input  fifo_ne_i, fifo_data_i, m_ready_i,
    output fifo_rd_o, fifo_oe_o, m_valid_o, m_data_o
  );

  modport slave (
    output fifo_ne_i, fifo_data_i, m_ready_i,
    input  fifo_rd_o, fifo_oe_o, m_valid_o, m_data_o
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Bounded-burst FIFO drain into a valid/ready stream; words appear 2 edges after their read strobe.
// Backpressure: reads stop once queued + in-flight words fill the skid queue; head held while stalled.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 18,
  parameter int BUF_DEPTH  = 3,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk_rd_i,
  input  logic                 mrst_n_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] burst_len_i,
  input  logic                 flush_i,
  fifo_rd_stream_if.master     bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [LEN_WIDTH-1:0] word_cnt_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                 state;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   issued_q;
  logic [LEN_WIDTH-1:0]   issued_nxt;
  logic                   rd_q;
  logic [DATA_WIDTH-1:0]  mem [BUF_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [OCC_W-1:0]       occ;
  logic [OCC_W:0]         pend;
  logic                   at_len;
  logic                   room;
  logic                   rd;
  logic                   last_issue;
  logic                   push;
  logic                   pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Words already queued plus the one still in the FIFO's output latch bound new issues.
  assign pend       = {1'b0, occ} + (OCC_W+1)'(rd_q);
  assign room       = pend < (OCC_W+1)'(BUF_DEPTH);
  assign at_len     = (len_q != '0) && (issued_q == len_q);
  assign rd         = (state == STREAM) && bus.fifo_ne_i && room && !at_len && !flush_i;
  assign issued_nxt = issued_q + LEN_WIDTH'(rd);
  assign last_issue = rd && (len_q != '0) && (issued_nxt == len_q);

  assign push = rd_q;
  assign pop  = bus.m_valid_o && bus.m_ready_i;

  assign bus.fifo_rd_o = rd;
  assign bus.fifo_oe_o = busy_o | rd_q;
  assign bus.m_valid_o = (occ != '0);
  assign bus.m_data_o  = mem[rd_ptr];
  assign busy_o        = (state != IDLE);

  always_ff @(posedge clk_rd_i or negedge mrst_n_i) begin
    if (!mrst_n_i) begin
      state      <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      word_cnt_o <= '0;
      done_o     <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      rd_q     <= rd;
      done_o   <= 1'b0;
      issued_q <= issued_nxt;
      if (pop) begin
        word_cnt_o <= word_cnt_o + LEN_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= STREAM;
            len_q      <= burst_len_i;
            issued_q   <= '0;
            word_cnt_o <= '0;
          end
        end
        STREAM: begin
          if (flush_i || last_issue) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((occ == '0) && !rd_q && !rd) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_rd_i or negedge mrst_n_i) begin
    if (!mrst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.fifo_data_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO model with one-cycle read latency, scoreboard on the stream.
module tb_fifo_rd_stream;
  localparam int DW = 18;
  localparam int LW = 16;

  logic          clk_rd_i    = 1'b0;
  logic          mrst_n_i    = 1'b0;
  logic          start_i     = 1'b0;
  logic [LW-1:0] burst_len_i = '0;
  logic          flush_i     = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [LW-1:0] word_cnt_o;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(3), .LEN_WIDTH(LW)) dut (
    .clk_rd_i    (clk_rd_i),
    .mrst_n_i    (mrst_n_i),
    .start_i     (start_i),
    .burst_len_i (burst_len_i),
    .flush_i     (flush_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .word_cnt_o  (word_cnt_o)
  );

  always #5 clk_rd_i = ~clk_rd_i;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            strobe_cyc[$];
  logic [DW-1:0] fifo_lat = '0;
  int            avail    = 0;
  int            strobes  = 0;
  int            cyc      = 0;
  logic          ne_block = 1'b0;
  int            done_cnt = 0;
  logic          prev_done  = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dat   = '0;

  assign bus.fifo_ne_i   = (avail != 0) && !ne_block;
  assign bus.fifo_data_i = bus.fifo_oe_o ? fifo_lat : 'z;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: the latch updates on the edge that samples rd with the flag high.
  always @(posedge clk_rd_i) begin
    logic [DW-1:0] w;
    cyc <= cyc + 1;
    if (bus.fifo_rd_o && bus.fifo_ne_i) begin
      w = fifo_q.pop_front();
      fifo_lat <= w;
      strobes  <= strobes + 1;
      strobe_cyc.push_back(cyc);
    end
    avail <= fifo_q.size();
  end

  // Stream monitor: sampled after the negedge, so the handshake completes on the next posedge.
  always @(negedge clk_rd_i) begin
    #2;
    if (mrst_n_i) begin
      if (prev_stall && bus.m_valid_o) check("hold", 64'(bus.m_data_o), 64'(prev_dat));
      if (bus.m_valid_o && bus.m_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word actual=%0h expected=none t=%0t", bus.m_data_o, $time);
        end else begin
          check("data", 64'(bus.m_data_o), 64'(exp_q.pop_front()));
        end
      end
      if (done_o) begin
        check("done_pulse", 64'(prev_done), 64'd0);
        done_cnt++;
      end
      prev_stall = bus.m_valid_o && !bus.m_ready_i;
      prev_dat   = bus.m_data_o;
      prev_done  = done_o;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_rd_i);
  endtask

  task automatic load(input int n, input logic [DW-1:0] base, input int ndel);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(DW'(base + DW'(i)));
      if (i < ndel) exp_q.push_back(DW'(base + DW'(i)));
    end
  endtask

  task automatic start_burst(input int len);
    start_i     = 1'b1;
    burst_len_i = LW'(len);
    tick(1);
    start_i     = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input string name);
    for (int k = 0; k < 200 && strobes < target; k++) tick(1);
    if (strobes < target) begin
      checks++;
      errors++;
      $display("FAIL %s_strobe_timeout actual=%0d expected=%0d", name, strobes, target);
    end
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    for (int k = 0; k < 300 && done_cnt == d0; k++) tick(1);
    check({name, "_done"}, 64'(done_cnt - d0), 64'd1);
    tick(2);
    check({name, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  task automatic drop_fifo();
    fifo_q.delete();
    tick(2);
  endtask

  initial begin
    int s0;
    int d0;
    bus.m_ready_i = 1'b1;
    #1;
    check("rst_rd",    64'(bus.fifo_rd_o), 64'd0);
    check("rst_oe",    64'(bus.fifo_oe_o), 64'd0);
    check("rst_valid", 64'(bus.m_valid_o), 64'd0);
    check("rst_data",  64'(bus.m_data_o),  64'd0);
    check("rst_busy",  64'(busy_o),        64'd0);
    check("rst_done",  64'(done_o),        64'd0);
    check("rst_cnt",   64'(word_cnt_o),    64'd0);
    tick(3);
    mrst_n_i = 1'b1;
    tick(2);

    // 1: bounded burst of 4 out of 8 available, full throughput
    s0 = strobes;
    load(8, 18'h100, 4);
    start_burst(4);
    wait_done("t1");
    check("t1_strobes", 64'(strobes - s0), 64'd4);
    check("t1_b2b", 64'(strobe_cyc[s0+3] - strobe_cyc[s0]), 64'd3);
    check("t1_cnt", 64'(word_cnt_o), 64'd4);
    check("t1_left", 64'(fifo_q.size()), 64'd4);
    check("t1_exp", 64'(exp_q.size()), 64'd0);
    drop_fifo();

    // 2: consumer stalled, issue stops at queue capacity
    s0 = strobes;
    bus.m_ready_i = 1'b0;
    load(6, 18'h200, 6);
    start_burst(6);
    tick(10);
    check("t2_strobes_stall", 64'(strobes - s0), 64'd3);
    check("t2_rd_stall", 64'(bus.fifo_rd_o), 64'd0);
    check("t2_valid", 64'(bus.m_valid_o), 64'd1);
    check("t2_head", 64'(bus.m_data_o), 64'h200);
    bus.m_ready_i = 1'b1;
    wait_done("t2");
    check("t2_strobes", 64'(strobes - s0), 64'd6);
    check("t2_cnt", 64'(word_cnt_o), 64'd6);
    check("t2_exp", 64'(exp_q.size()), 64'd0);
    drop_fifo();

    // 3: unbounded burst cut short by flush after the third strobe
    s0 = strobes;
    load(5, 18'h300, 3);
    start_burst(0);
    wait_strobes(s0 + 3, "t3");
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
    wait_done("t3");
    check("t3_strobes", 64'(strobes - s0), 64'd3);
    check("t3_cnt", 64'(word_cnt_o), 64'd3);
    check("t3_left", 64'(fifo_q.size()), 64'd2);
    drop_fifo();

    // 4: FIFO flag drops for 4 cycles mid-burst
    s0 = strobes;
    load(5, 18'h3ff00, 5);
    start_burst(5);
    wait_strobes(s0 + 2, "t4");
    ne_block = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t4_rd_empty", 64'(bus.fifo_rd_o), 64'd0);
      tick(1);
    end
    check("t4_strobes_gap", 64'(strobes - s0), 64'd2);
    ne_block = 1'b0;
    wait_done("t4");
    check("t4_strobes", 64'(strobes - s0), 64'd5);
    check("t4_cnt", 64'(word_cnt_o), 64'd5);
    drop_fifo();

    // 5: reset with 2 queued words and 1 in flight
    s0 = strobes;
    bus.m_ready_i = 1'b0;
    load(4, 18'h500, 0);
    start_burst(0);
    wait_strobes(s0 + 3, "t5");
    check("t5_pre_valid", 64'(bus.m_valid_o), 64'd1);
    d0 = done_cnt;
    mrst_n_i = 1'b0;
    #1;
    check("t5_rd",    64'(bus.fifo_rd_o), 64'd0);
    check("t5_oe",    64'(bus.fifo_oe_o), 64'd0);
    check("t5_valid", 64'(bus.m_valid_o), 64'd0);
    check("t5_data",  64'(bus.m_data_o),  64'd0);
    check("t5_busy",  64'(busy_o),        64'd0);
    check("t5_cnt",   64'(word_cnt_o),    64'd0);
    tick(3);
    mrst_n_i = 1'b1;
    tick(3);
    check("t5_nodone", 64'(done_cnt - d0), 64'd0);
    check("t5_idle", 64'(busy_o), 64'd0);
    check("t5_valid_after", 64'(bus.m_valid_o), 64'd0);
    bus.m_ready_i = 1'b1;
    drop_fifo();

    // 6: start ignored in STREAM and DRAIN; len=0 without flush stays busy
    s0 = strobes;
    d0 = done_cnt;
    load(3, 18'h600, 3);
    start_burst(0);
    tick(10);
    check("t6_busy", 64'(busy_o), 64'd1);
    check("t6_cnt3", 64'(word_cnt_o), 64'd3);
    start_burst(2);
    tick(3);
    load(2, 18'h610, 2);
    tick(8);
    check("t6_cnt5", 64'(word_cnt_o), 64'd5);
    check("t6_busy2", 64'(busy_o), 64'd1);
    bus.m_ready_i = 1'b0;
    load(2, 18'h620, 2);
    tick(8);
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
    tick(2);
    start_burst(1);
    check("t6_drain_busy", 64'(busy_o), 64'd1);
    check("t6_drain_valid", 64'(bus.m_valid_o), 64'd1);
    check("t6_nodone", 64'(done_cnt - d0), 64'd0);
    bus.m_ready_i = 1'b1;
    wait_done("t6");
    check("t6_cnt7", 64'(word_cnt_o), 64'd7);
    check("t6_strobes", 64'(strobes - s0), 64'd7);
    tick(5);
    check("t6_stay_idle", 64'(busy_o), 64'd0);
    check("final_exp", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
